// File: rtl/osc_tick_sched_if.sv
// Request/tick bundle between the tick scheduler and its requesters.
// Requesters (master) drive req/div. The scheduler (slave) returns ready, tick, active and overrun.
interface osc_tick_sched_if #(
    parameter int NCH   = 4,
    parameter int DIV_W = 16
);
    logic [NCH-1:0]       req;
    logic [NCH*DIV_W-1:0] div;
    logic                 ready;
    logic [NCH-1:0]       tick;
    logic [NCH-1:0]       active;
    logic [NCH-1:0]       overrun;

    modport master (output req, div, input ready, tick, active, overrun);
    modport slave  (input req, div, output ready, tick, active, overrun);
endinterface

// File: rtl/osc_tick_sched.sv
// Multi-channel clock-enable tick scheduler. It waits for the oscillator to settle.
// Ticks are mutually exclusive and resolved by fixed priority, with one pending slot per channel.
module osc_tick_sched #(
    parameter int NCH    = 4,
    parameter int DIV_W  = 16,
    parameter int SETTLE = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    osc_tick_sched_if.slave  bus
);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] LAST = CW'(SETTLE - 1);

    typedef enum logic {G_SETTLE, G_RUN} g_state_t;
    typedef enum logic {CH_IDLE, CH_ACTIVE} ch_state_t;

    g_state_t        g_q, g_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            go;

    ch_state_t       ch_q [NCH];
    ch_state_t       ch_d [NCH];
    logic [DIV_W-1:0] c_q   [NCH];
    logic [DIV_W-1:0] c_d   [NCH];
    logic [DIV_W-1:0] dm1_q [NCH];
    logic [DIV_W-1:0] dm1_d [NCH];
    logic [NCH-1:0]  pend_q, pend_d, ovr_q, ovr_d, tick_q, tick_d;
    logic [NCH-1:0]  due, cand, win, act_vec;
    logic            found;

    // go is also high on the terminal settle edge so channels can be accepted the same edge ready rises
    always_comb begin
        g_d   = g_q;
        cnt_d = cnt_q;
        go    = (g_q == G_RUN);
        if (g_q == G_SETTLE) begin
            if (cnt_q == LAST) begin
                g_d = G_RUN;
                go  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        found  = 1'b0;
        win    = '0;
        due    = '0;
        cand   = '0;
        pend_d = pend_q;
        ovr_d  = ovr_q;
        for (int i = 0; i < NCH; i++) begin
            ch_d[i]  = ch_q[i];
            c_d[i]   = c_q[i];
            dm1_d[i] = dm1_q[i];
            due[i]   = (ch_q[i] == CH_ACTIVE) && (c_q[i] == dm1_q[i]);
            cand[i]  = (ch_q[i] == CH_ACTIVE) && bus.req[i] && (due[i] || pend_q[i]);
            if (cand[i] && !found) begin
                win[i] = 1'b1;
                found  = 1'b1;
            end
            if (ch_q[i] == CH_IDLE) begin
                if (bus.req[i] && go) begin
                    ch_d[i]  = CH_ACTIVE;
                    c_d[i]   = '0;
                    dm1_d[i] = (bus.div[i*DIV_W +: DIV_W] == '0) ? '0
                             : bus.div[i*DIV_W +: DIV_W] - 1'b1;
                end
            end else if (!bus.req[i]) begin
                ch_d[i]   = CH_IDLE;
                c_d[i]    = '0;
                pend_d[i] = 1'b0;
                ovr_d[i]  = 1'b0;
            end else begin
                c_d[i] = due[i] ? '0 : c_q[i] + 1'b1;
                // A winner that was also due keeps that due tick as pending
                pend_d[i] = win[i] ? (pend_q[i] & due[i]) : (pend_q[i] | due[i]);
                ovr_d[i]  = ovr_q[i] | (pend_q[i] & due[i] & ~win[i]);
            end
        end
        tick_d = win;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_q    <= G_SETTLE;
            cnt_q  <= '0;
            pend_q <= '0;
            ovr_q  <= '0;
            tick_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                ch_q[i]  <= CH_IDLE;
                c_q[i]   <= '0;
                dm1_q[i] <= '0;
            end
        end else begin
            g_q    <= g_d;
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            ovr_q  <= ovr_d;
            tick_q <= tick_d;
            for (int i = 0; i < NCH; i++) begin
                ch_q[i]  <= ch_d[i];
                c_q[i]   <= c_d[i];
                dm1_q[i] <= dm1_d[i];
            end
        end
    end

    always_comb begin
        act_vec = '0;
        for (int i = 0; i < NCH; i++) act_vec[i] = (ch_q[i] == CH_ACTIVE);
    end

    assign bus.ready   = (g_q == G_RUN);
    assign bus.tick    = tick_q;
    assign bus.active  = act_vec;
    assign bus.overrun = ovr_q;
endmodule

// File: tb/tb_osc_tick_sched.sv
// Bench for osc_tick_sched. It compares the DUT against a reference model of tick timing.
// The model computes due ticks from the acceptance edge and the divisor.
module tb_osc_tick_sched;
    localparam int NCH    = 4;
    localparam int DIV_W  = 16;
    localparam int SETTLE = 16;
    localparam int VW     = 3*NCH + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    osc_tick_sched_if #(.NCH(NCH), .DIV_W(DIV_W)) bus ();

    osc_tick_sched #(.NCH(NCH), .DIV_W(DIV_W), .SETTLE(SETTLE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [VW-1:0] exp_q [$];

    int             m_edge;
    bit             m_ready;
    bit             m_act  [NCH];
    int             m_d    [NCH];
    int             m_k    [NCH];
    int             m_pend [NCH];
    bit             m_ovr  [NCH];
    logic [NCH-1:0] m_tick;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_edge  = 0;
        m_ready = 1'b0;
        m_tick  = '0;
        for (int i = 0; i < NCH; i++) begin
            m_act[i]  = 1'b0;
            m_d[i]    = 1;
            m_k[i]    = 0;
            m_pend[i] = 0;
            m_ovr[i]  = 1'b0;
        end
    endtask

    // A channel accepted at edge k with period D is due at every edge k + n*D (n >= 1)
    task automatic model_step();
        int             e;
        bit             go;
        bit             taken;
        bit             due;
        int             cnt;
        logic [NCH-1:0] act_v;
        logic [NCH-1:0] ovr_v;
        e     = m_edge + 1;
        go    = (e >= SETTLE);
        taken = 1'b0;
        m_tick = '0;
        for (int i = 0; i < NCH; i++) begin
            due = m_act[i] && (((e - m_k[i]) % m_d[i]) == 0);
            if (!m_act[i]) begin
                if (bus.req[i] && go) begin
                    m_act[i] = 1'b1;
                    m_k[i]   = e;
                    m_d[i]   = (bus.div[i*DIV_W +: DIV_W] == 0) ? 1 : int'(bus.div[i*DIV_W +: DIV_W]);
                end
            end else if (!bus.req[i]) begin
                m_act[i]  = 1'b0;
                m_pend[i] = 0;
                m_ovr[i]  = 1'b0;
            end else begin
                cnt = m_pend[i] + (due ? 1 : 0);
                if (cnt > 0 && !taken) begin
                    m_tick[i] = 1'b1;
                    taken     = 1'b1;
                    cnt--;
                end
                if (cnt > 1) m_ovr[i] = 1'b1;
                m_pend[i] = (cnt > 1) ? 1 : cnt;
            end
        end
        m_ready = go;
        m_edge  = e;
        for (int i = 0; i < NCH; i++) begin
            act_v[i] = m_act[i];
            ovr_v[i] = m_ovr[i];
        end
        exp_q.push_back({ovr_v, act_v, m_tick, m_ready});
    endtask

    task automatic cycle();
        logic [VW-1:0] exp;
        @(posedge clk);
        model_step();
        @(negedge clk);
        exp = exp_q.pop_front();
        check("ready",   32'(bus.ready),   32'(exp[0]));
        check("tick",    32'(bus.tick),    32'(exp[NCH:1]));
        check("active",  32'(bus.active),  32'(exp[2*NCH:NCH+1]));
        check("overrun", 32'(bus.overrun), 32'(exp[3*NCH:2*NCH+1]));
        check("tick_onehot", 32'($countones(bus.tick) <= 1), 32'd1);
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_ready"},   32'(bus.ready),   32'd0);
        check({pfx, "_tick"},    32'(bus.tick),    32'd0);
        check({pfx, "_active"},  32'(bus.active),  32'd0);
        check({pfx, "_overrun"}, 32'(bus.overrun), 32'd0);
    endtask

    // Called at a negedge: reset lands between edges, then releases on a later negedge
    task automatic mid_reset();
        #2 rst_n = 1'b0;
        #1 check_zero("async_rst");
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_div(input int ch, input int v);
        bus.div[ch*DIV_W +: DIV_W] = DIV_W'(v);
    endtask

    initial begin
        logic [NCH-1:0] r;
        bus.req = '0;
        bus.div = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_zero("reset");

        // Settle then a single channel of period 4
        bus.req = 4'b0001;
        set_div(0, 4);
        rst_n = 1'b1;
        repeat (40) cycle();

        // Two independent rates with a collision
        bus.req = '0;
        cycle();
        set_div(0, 3);
        set_div(1, 5);
        bus.req = 4'b0011;
        repeat (40) cycle();

        // Channel 1 starved, then released, then dropped while pending
        bus.req = '0;
        cycle();
        set_div(0, 1);
        set_div(1, 2);
        bus.req = 4'b0011;
        repeat (8) cycle();
        bus.req = 4'b0010;
        repeat (3) cycle();
        bus.req = 4'b0011;
        repeat (6) cycle();
        bus.req = 4'b0001;
        repeat (3) cycle();

        // Zero divisor and an ignored divisor change while active
        bus.req = '0;
        cycle();
        set_div(2, 0);
        bus.req = 4'b0100;
        repeat (5) cycle();
        set_div(2, 7);
        repeat (10) cycle();
        bus.req = '0;
        cycle();
        bus.req = 4'b0100;
        repeat (20) cycle();

        // Asynchronous reset while ticks run
        set_div(0, 2);
        set_div(1, 3);
        bus.req = 4'b0111;
        repeat (5) cycle();
        mid_reset();
        repeat (30) cycle();

        for (int n = 0; n < 3000; n++) begin
            r = bus.req;
            for (int i = 0; i < NCH; i++) begin
                if ($urandom_range(0, 15) == 0) begin
                    r[i] = ~r[i];
                    set_div(i, int'($urandom_range(0, 9)));
                end
            end
            bus.req = r;
            if ($urandom_range(0, 999) == 0) mid_reset();
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/osc_tick_sched.md
# osc_tick_sched

Multi-channel tick scheduler driven by the on-chip oscillator clock (GW1N-9 internal OSC, FREQ_DIV 10). It holds all consumers off until the oscillator has settled. It then generates one-cycle clock-enable ticks for up to NCH requesters (SPI SCLK enables, sample strobes), each with its own divisor. Tick outputs are mutually exclusive; collisions are resolved by fixed priority with a one-deep pending slot per channel.

## Interface
- NCH, 4: number of requester channels (1..8)
- DIV_W, 16: divisor width per channel
- SETTLE, 1024: oscillator settle time in clk cycles after reset release (>=1)
- clk  in  1  oscillator clock (Gowin_OSC oscout)
- rst_n  in  1  asynchronous, active-low reset
- req  in  NCH  channel request; level, held high for as long as ticks are wanted
- div  in  NCH*DIV_W  divisor per channel; channel i uses bits [i*DIV_W +: DIV_W]
- ready  out  1  settle period complete
- tick  out  NCH  one-cycle enable per channel; at most one bit high per cycle
- active  out  NCH  channel accepted and running
- overrun  out  NCH  sticky per-channel lost-tick flag

## Operation
- Global FSM, two states:
  - SETTLE (reset state): counter runs 0..SETTLE-1. At terminal count, go to RUN and set ready.
  - RUN: terminal state, left only by reset.
- Per-channel FSM:
  - IDLE -> ACTIVE when req[i]=1 and ready=1 at an edge. On that edge, latch div[i] as D_i (0 is treated as 1) and clear phase counter c_i to 0.
  - ACTIVE -> IDLE when req[i]=0 at an edge. On that edge, clear c_i, pending_i and overrun[i]; no tick is issued that cycle.
  - Changes on div[i] while ACTIVE are ignored until the next IDLE->ACTIVE.
- Phase counter (ACTIVE only):
  - c_i increments every cycle and wraps to 0 when it reaches D_i-1. The wrap cycle is a due event.
  - Counters never stall, so the long-term period is exactly D_i whatever the collisions.
- Arbitration each cycle:
  - Candidates are channels that are due or have pending set.
  - The lowest index wins and asserts tick, clearing its pending.
  - Each losing due channel sets pending.
  - A channel that is due while its pending is already set sets overrun[i] (sticky) and keeps a single pending tick; the extra tick is lost.
- tick, active and overrun are registered outputs.

## Timing
- Reset values: ready=0, tick=0, active=0, overrun=0, all counters 0, all pending 0, FSM in SETTLE. Reset is effective asynchronously at any point, including mid-tick or mid-settle.
- ready goes high at the SETTLE-th rising edge after rst_n deasserts.
- req high while ready=0 is ignored; the channel is accepted at the first edge where ready=1.
- Acceptance at edge k: active rises at edge k. Without contention, the first tick is high from edge k+D_i to k+D_i+1, then every D_i cycles. D_i=1 gives tick high every cycle from edge k+1.
- A delayed (pending) tick is issued on the first cycle the channel wins. Pending does not accumulate beyond 1.
- req falling at edge m: active and tick are low from edge m, even if a tick was due or pending at m.
- Channel 0 is never delayed. For NCH=1 the block reduces to a plain divider after settle.

## Test plan
- Reset/settle: SETTLE=16, req=4'b0001, D0=4 -> ready rises at edge 16, active[0] at edge 16, tick[0] at edges 20, 24, 28.
- Independent rates: D0=3, D1=5 accepted at the same edge k -> tick[0] at k+3, k+6, k+9, k+12, k+18. Collision at k+15: tick[0] at k+15 and tick[1] at k+16 (pending). tick[1] at k+5, k+10, k+16, k+20. No overrun.
- Overrun: D0=1, D1=2 -> channel 0 ticks every cycle and channel 1 never wins. After two due events, overrun[1]=1 and no tick[1] appears. Dropping req[0] causes one tick[1] on the next cycle.
- div=0 and mid-run div change: D2=0 behaves as 1. Changing div[2] from 0 to 7 while active leaves the period unchanged; a req drop and reassert gives period 7.
- Release mid-pending: drop req[1] on a cycle when pending_1=1 -> no tick[1], active[1]=0, overrun[1] cleared.
- Async reset mid-run: assert rst_n=0 between edges while ticks are running -> all outputs 0 immediately. After release, SETTLE cycles elapse before any tick.
